// File: rtl/j4_slot_supervisor.sv
// Per-slot run/halt/kill supervisor and watchdog for the 4-slot barrel core.
// Optional watchdog logic is built only when J4_SLOT_SUPERVISOR_WDOG_EN is defined.
module j4_slot_supervisor #(
  parameter logic [15:0] CTRL_ADDR = 16'h0100,
  parameter logic [15:0] WDOG_ADDR = 16'h0102,
  parameter logic [15:0] STAT_ADDR = 16'h0104,
  parameter logic [3:0]  BOOT_MASK = 4'b0001,
  parameter logic [15:0] WDOG_LOAD = 16'd1000,
  parameter int          PRESCALE  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [1:0]  io_slot,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] rd_data,
  output logic        rd_hit,
  output logic [3:0]  kill_slot_rq,
  output logic [3:0]  slot_halted,
  output logic [3:0]  wdog_expired
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} slot_state_e;

  slot_state_e r_state     [4];
  slot_state_e w_state_nxt [4];
  logic [3:0]  w_halted;
  logic [3:0]  w_halted_nxt;
  logic        w_ctrl_wr;
  logic        w_stat_rd;
  logic [3:0]  w_kill_sw;
  logic [3:0]  w_hset;
  logic [3:0]  w_hclr;
  logic [3:0]  w_wdog_kill;
  logic [3:0]  w_wdog_en;
  logic [3:0]  w_wdog_expired;
  logic [3:0]  r_kill;
  logic [15:0] r_rd_data;
  logic        r_rd_hit;

  assign w_ctrl_wr = io_wr && (mem_addr == CTRL_ADDR);
  assign w_stat_rd = io_rd && (mem_addr == STAT_ADDR);
  assign w_kill_sw = w_ctrl_wr ? dout[3:0]  : 4'b0000;
  assign w_hset    = w_ctrl_wr ? dout[7:4]  : 4'b0000;
  assign w_hclr    = w_ctrl_wr ? dout[11:8] : 4'b0000;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_state_nxt[n] = r_state[n];
      if (w_hset[n])      w_state_nxt[n] = S_HALT;
      else if (w_hclr[n]) w_state_nxt[n] = S_RUN;
      w_halted[n]     = (r_state[n] == S_HALT);
      w_halted_nxt[n] = (w_state_nxt[n] == S_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) r_state[n] <= BOOT_MASK[n] ? S_RUN : S_HALT;
      r_kill    <= ~BOOT_MASK;
      r_rd_data <= 16'h0000;
      r_rd_hit  <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) r_state[n] <= w_state_nxt[n];
      // A halted slot holds its request; kill pulses only add a one-cycle request.
      r_kill   <= w_halted_nxt | w_kill_sw | w_wdog_kill;
      r_rd_hit <= w_stat_rd;
      if (w_stat_rd)
        r_rd_data <= {io_slot, 2'b00, w_wdog_en, w_wdog_expired, w_halted};
    end
  end

`ifdef J4_SLOT_SUPERVISOR_WDOG_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [3:0]    r_wdog_en;
  logic [3:0]    r_expired;
  logic [15:0]   r_cnt [4];
  logic [3:0]    w_en_nxt;
  logic [3:0]    w_kick;
  logic [3:0]    w_dec;
  logic [3:0]    w_reload;

  assign w_tick   = (r_presc == PW'(PRESCALE - 1));
  assign w_en_nxt = w_ctrl_wr ? dout[15:12] : r_wdog_en;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_kick[n]      = io_wr && (mem_addr == WDOG_ADDR) && (io_slot == n[1:0]);
      w_dec[n]       = w_tick && r_wdog_en[n] && (r_state[n] == S_RUN);
      // A kick in the same cycle as the final tick wins: no expiry.
      w_wdog_kill[n] = w_dec[n] && (r_cnt[n] == 16'd1) && !w_kick[n];
      w_reload[n]    = w_kick[n] || w_hclr[n] || (w_en_nxt[n] && !r_wdog_en[n]);
    end
  end

  // NOTE: the counter array is a handful of flops with defined reset values, not a RAM, so it is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_wdog_en <= 4'b0000;
      r_expired <= 4'b0000;
      for (int n = 0; n < 4; n++) r_cnt[n] <= WDOG_LOAD;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;
      r_wdog_en <= w_en_nxt;
      for (int n = 0; n < 4; n++) begin
        if (w_reload[n] || w_wdog_kill[n]) r_cnt[n] <= WDOG_LOAD;
        else if (w_dec[n])                 r_cnt[n] <= r_cnt[n] - 16'd1;
        if (w_kick[n])           r_expired[n] <= 1'b0;
        else if (w_wdog_kill[n]) r_expired[n] <= 1'b1;
      end
    end
  end

  assign w_wdog_en      = r_wdog_en;
  assign w_wdog_expired = r_expired;
`else
  logic w_unused_wdog;

  assign w_unused_wdog  = ^{dout[15:12], WDOG_ADDR, WDOG_LOAD, (PRESCALE > 1)};
  assign w_wdog_kill    = 4'b0000;
  assign w_wdog_en      = 4'b0000;
  assign w_wdog_expired = 4'b0000;
`endif

  assign kill_slot_rq = r_kill;
  assign slot_halted  = w_halted;
  assign wdog_expired = w_wdog_expired;
  assign rd_data      = r_rd_data;
  assign rd_hit       = r_rd_hit;

endmodule
